ram_param: RTL and testbench
============================

Name: ram_param

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 8-bit, 12-entry bus memory.
- Sits behind the bus slave interface as the local data store.
- Adds a valid/ready request handshake and configurable read latency (1 or 2).
- Adds a post-reset hardware clear sweep and out-of-range address detection with an error flag.

Parameters:
DATA_W, 8, data word width in bits.
ADDR_W, 12, address port width in bits.
DEPTH, 4096, number of words; must be >= 1 and <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles from accept to rd_valid; legal values 1 or 2.
INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip the sweep and leave contents unchanged.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_wr  input  1  1 = write, 0 = read; qualified by req_valid.
req_addr  input  ADDR_W  word address.
req_wdata  input  DATA_W  write data.
rd_valid  output  1  rd_data is valid this cycle (one-cycle pulse per read).
rd_data  output  DATA_W  read data.
init_busy  output  1  clear sweep in progress.
addr_err  output  1  one-cycle pulse flagging an out-of-range access.

Behaviour:
- Reset state: req_ready=0, rd_valid=0, rd_data=0, addr_err=0, and the read pipeline is flushed.
- Reset with INIT_CLEAR=1:
  - init_busy=1 and the sweep counter is set to 0.
  - The FSM enters INIT.
- Reset with INIT_CLEAR=0:
  - init_busy=0 and the FSM enters RUN.
  - req_ready=1 from the first cycle after rst deasserts.
- INIT state:
  - Writes 0 to one address per cycle, in order 0..DEPTH-1.
  - Takes exactly DEPTH cycles after rst deasserts.
  - After the cycle that writes DEPTH-1, init_busy=0, req_ready=1 and the FSM moves to RUN.
  - req_valid is ignored while in INIT; no request is accepted.
- RUN state:
  - req_ready = 1 continuously, so the block takes 1 request per cycle and needs no backpressure.
  - Accept condition: req_valid && req_ready, sampled at the clock edge.
- Write, in range (addr < DEPTH): mem[addr] is updated at the accept edge; rd_valid is not asserted.
- Read, in range:
  - rd_valid pulses high exactly RD_LAT cycles after the accept edge, with rd_data = mem[addr].
  - Back-to-back reads produce back-to-back rd_valid pulses in request order.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data.
- Out-of-range access (req_addr >= DEPTH):
  - Write: the array is not modified.
  - Read: rd_data = 0, and rd_valid still pulses with the normal latency.
  - addr_err pulses for one cycle, 1 cycle after the accept edge, for both reads and writes.
- rd_data holds its last value while rd_valid=0; only a read completion or rst changes it.
- Reset mid-INIT: the sweep restarts at address 0 and the full DEPTH cycles are taken again.
- Reset mid-read: pending rd_valid pulses are dropped; no rd_valid follows a reset.
- Address width: only req_addr bits needed to index DEPTH select the word; the full ADDR_W value is used for the range check.
- Array contents are not cleared by rst when INIT_CLEAR=0.

Test Plan:
- INIT_CLEAR=1, DEPTH=16: hold rst 2 cycles, then release -> init_busy=1 for exactly 16 cycles and req_ready rises on cycle 17; read addr 0..15 -> all return 0x00.
- RD_LAT=1: write 0xA5 @ 0x003, then read @ 0x003 on the next cycle -> rd_valid on the cycle after the read accept with rd_data=0xA5; read-after-write returns the new value.
- RD_LAT=2: reads of @1, @2, @3 on three consecutive cycles (preloaded 0x11, 0x22, 0x33) -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first accept, with data 0x11, 0x22, 0x33.
- DEPTH=12, ADDR_W=12, preload 0x5A @ 0x00C: write 0xFF @ 0x00C -> addr_err pulses once and no write occurs; read @ 0x00C -> rd_valid with rd_data=0x00 and addr_err pulses; read @ 0x00B still returns its prior value.
- Assert rst for 1 cycle with INIT at address 7 -> sweep restarts at 0 and init_busy stays high for DEPTH more cycles; assert rst 1 cycle after a read accept with RD_LAT=2 -> no rd_valid is ever produced.
- INIT_CLEAR=0: write 0x3C @ 5, pulse rst, read @ 5 -> req_ready=1 on the first cycle after reset, rd_data=0x3C (contents survive reset).

Source files
------------

// File: rtl/ram_param.sv
// ---------------------------------------------------------------------------
// ram_param : parametrised single-port synchronous RAM used as the local data
// store behind the bus slave. Requests use a valid/ready handshake. Reads
// complete after RD_LAT (1 or 2) cycles. An optional hardware sweep zeroes
// the array after reset. Out-of-range accesses raise a one-cycle error pulse.
//
// Parameters
//   DATA_W     word width in bits
//   ADDR_W     address port width in bits
//   DEPTH      number of words, 1 <= DEPTH <= 2**ADDR_W
//   RD_LAT     read latency from accept edge to rd_valid, 1 or 2
//   INIT_CLEAR 1 = zero every word after reset, 0 = keep contents
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_wr     1 = write, 0 = read
//   req_addr   word address (full width used for the range check)
//   req_wdata  write data
//   rd_valid   one-cycle pulse per completed read
//   rd_data    read data, held between completions
//   init_busy  clear sweep in progress
//   addr_err   one-cycle pulse, one cycle after an out-of-range accept
// ---------------------------------------------------------------------------
module ram_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4096,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              init_busy,
    output logic              addr_err
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable for the compare.
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IDX_W-1:0]    clr_cnt_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                accept_s;
    logic                in_range_s;
    logic                rd_req_s;
    logic [IDX_W-1:0]    idx_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                fin_v_s;
    logic [DATA_W-1:0]   fin_d_s;

    logic                p1_v_r;
    logic [DATA_W-1:0]   p1_d_r;
    logic                rd_valid_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                addr_err_r;

    assign in_range_s = ({1'b0, req_addr} < DEPTH_V);
    assign idx_s      = req_addr[IDX_W-1:0];
    assign accept_s   = req_valid && (state_r == ST_RUN);
    assign rd_req_s   = accept_s && !req_wr;
    // Out-of-range reads return zero rather than an aliased word.
    assign rd_word_s  = in_range_s ? mem_r[idx_s] : {DATA_W{1'b0}};

    // FSM state register; reset picks the sweep or goes straight to service.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: leave INIT after the cycle that clears the last word.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (clr_cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Sweep address counter, restarted from zero by every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_r <= {IDX_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            clr_cnt_r <= clr_cnt_r + IDX_W'(1);
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_INIT) begin
                mem_r[clr_cnt_r] <= {DATA_W{1'b0}};
            end else if (accept_s && req_wr && in_range_s) begin
                mem_r[idx_s] <= req_wdata;
            end
        end
    end

    // Extra read stage, only observed when RD_LAT is 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_v_r <= 1'b0;
            p1_d_r <= {DATA_W{1'b0}};
        end else begin
            p1_v_r <= rd_req_s;
            p1_d_r <= rd_word_s;
        end
    end

    // Select which stage feeds the output register for the chosen latency.
    always_comb begin
        fin_v_s = 1'b0;
        fin_d_s = {DATA_W{1'b0}};
        if (RD_LAT == 1) begin
            fin_v_s = rd_req_s;
            fin_d_s = rd_word_s;
        end else begin
            fin_v_s = p1_v_r;
            fin_d_s = p1_d_r;
        end
    end

    // Output registers; rd_data only moves on a read completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_W{1'b0}};
            addr_err_r <= 1'b0;
        end else begin
            rd_valid_r <= fin_v_s;
            if (fin_v_s) begin
                rd_data_r <= fin_d_s;
            end
            addr_err_r <= accept_s && !in_range_s;
        end
    end

    // req_ready is masked by rst so it reads 0 while reset is held yet is
    // already 1 in the first cycle after release when no sweep is needed.
    assign req_ready = (state_r == ST_RUN) && !rst;
    assign init_busy = (state_r == ST_INIT);
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_ram_param.sv
// ---------------------------------------------------------------------------
// tb_ram_param : drives one shared request stream into three ram_param
// configurations and compares every output each cycle against a behavioural
// model (plain arrays, an init countdown and a small completion schedule).
//   u_a : DEPTH=12, RD_LAT=1, INIT_CLEAR=1
//   u_b : DEPTH=16, RD_LAT=2, INIT_CLEAR=1
//   u_c : DEPTH=16, RD_LAT=1, INIT_CLEAR=0
// ---------------------------------------------------------------------------
module tb_ram_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;

    logic [2:0]  rdy_w;
    logic [2:0]  busy_w;
    logic [2:0]  rv_w;
    logic [2:0]  err_w;
    logic [7:0]  rd_w0;
    logic [7:0]  rd_w1;
    logic [7:0]  rd_w2;

    always #5 clk = ~clk;

    ram_param #(.DATA_W(8), .ADDR_W(12), .DEPTH(12), .RD_LAT(1), .INIT_CLEAR(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[0]),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rv_w[0]), .rd_data(rd_w0), .init_busy(busy_w[0]), .addr_err(err_w[0])
    );

    ram_param #(.DATA_W(8), .ADDR_W(12), .DEPTH(16), .RD_LAT(2), .INIT_CLEAR(1)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[1]),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rv_w[1]), .rd_data(rd_w1), .init_busy(busy_w[1]), .addr_err(err_w[1])
    );

    ram_param #(.DATA_W(8), .ADDR_W(12), .DEPTH(16), .RD_LAT(1), .INIT_CLEAR(0)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[2]),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rv_w[2]), .rd_data(rd_w2), .init_busy(busy_w[2]), .addr_err(err_w[2])
    );

    // Reference model state
    int         depth_m [3];
    int         lat_m   [3];
    bit         iclr_m  [3];
    int         init_left [3];
    logic [7:0] mem_m   [3][16];
    bit         known_m [3][16];
    bit         pv      [3][4];
    logic [7:0] pd      [3][4];
    bit         pk      [3][4];
    bit         e_rv    [3];
    bit         e_err   [3];
    bit         e_rk    [3];
    logic [7:0] e_rd    [3];
    int         edge_n;
    int         checks;
    int         errors;

    function automatic logic [7:0] rd_of(int i);
        case (i)
            0:       return rd_w0;
            1:       return rd_w1;
            default: return rd_w2;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            bit inr;
            int slot;
            int a;
            if (rst) begin
                init_left[i] = iclr_m[i] ? depth_m[i] : 0;
                for (int k = 0; k < 4; k++) pv[i][k] = 1'b0;
                e_rv[i]  = 1'b0;
                e_rd[i]  = 8'h00;
                e_rk[i]  = 1'b1;
                e_err[i] = 1'b0;
            end else begin
                e_err[i] = 1'b0;
                if (init_left[i] > 0) begin
                    a = depth_m[i] - init_left[i];
                    mem_m[i][a]   = 8'h00;
                    known_m[i][a] = 1'b1;
                    init_left[i]--;
                end else if (req_valid) begin
                    a   = int'(req_addr);
                    inr = (a < depth_m[i]);
                    e_err[i] = !inr;
                    if (req_wr) begin
                        if (inr) begin
                            mem_m[i][a]   = req_wdata;
                            known_m[i][a] = 1'b1;
                        end
                    end else begin
                        slot = (edge_n + lat_m[i] - 1) % 4;
                        pv[i][slot] = 1'b1;
                        pd[i][slot] = inr ? mem_m[i][a] : 8'h00;
                        pk[i][slot] = inr ? known_m[i][a] : 1'b1;
                    end
                end
                slot = edge_n % 4;
                e_rv[i] = pv[i][slot];
                if (pv[i][slot]) begin
                    e_rd[i] = pd[i][slot];
                    e_rk[i] = pk[i][slot];
                    pv[i][slot] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk1(string tag, int i, logic got, logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] cyc=%0d observed=%b expected=%b", tag, i, edge_n, got, exp);
        end
    endtask

    task automatic chk8(string tag, int i, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, i, edge_n, got, exp);
        end
    endtask

    task automatic check_ready();
        for (int i = 0; i < 3; i++) begin
            chk1("req_ready", i, rdy_w[i], (init_left[i] == 0) && !rst);
        end
    endtask

    task automatic check_all();
        check_ready();
        for (int i = 0; i < 3; i++) begin
            chk1("init_busy", i, busy_w[i], init_left[i] > 0);
            chk1("rd_valid",  i, rv_w[i],   e_rv[i]);
            chk1("addr_err",  i, err_w[i],  e_err[i]);
            if (e_rk[i]) begin
                chk8("rd_data", i, rd_of(i), e_rd[i]);
            end
        end
    endtask

    // One clock: model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(bit v, bit w, int a, int d);
        req_valid = v;
        req_wr    = w;
        req_addr  = 12'(a);
        req_wdata = 8'(d);
        step();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0);
    endtask

    // Drop reset and check req_ready in the very first cycle afterwards.
    task automatic release_rst();
        rst = 1'b0;
        #1;
        check_ready();
    endtask

    task automatic rand_ops(int n, int rst_odds);
        for (int k = 0; k < n; k++) begin
            rst = (rst_odds > 0) && ($urandom_range(0, rst_odds - 1) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19), $urandom_range(0, 255));
        end
        rst = 1'b0;
    endtask

    initial begin
        depth_m = '{12, 16, 16};
        lat_m   = '{1, 2, 1};
        iclr_m  = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            init_left[i] = 0;
            e_rv[i] = 1'b0; e_err[i] = 1'b0; e_rk[i] = 1'b0; e_rd[i] = 8'h00;
            for (int k = 0; k < 4; k++) pv[i][k] = 1'b0;
            for (int k = 0; k < 16; k++) known_m[i][k] = 1'b0;
        end
        edge_n = 0; checks = 0; errors = 0;

        // Reset held for two cycles, then release
        rst = 1'b1;
        idle(2);
        release_rst();

        // Writes during the sweep: ignored by u_a/u_b, accepted by u_c
        for (int k = 0; k < 18; k++) drive(1'b1, 1'b1, $urandom_range(0, 20), $urandom_range(0, 255));
        idle(1);

        // Read back cleared words on the swept instances
        for (int a = 0; a < 16; a++) drive(1'b1, 1'b0, a, 0);
        idle(2);

        // Preload every word so u_c contents are fully known
        for (int a = 0; a < 16; a++) drive(1'b1, 1'b1, a, $urandom_range(0, 255));

        // Write then read the same address on the next cycle
        drive(1'b1, 1'b1, 3, 8'hA5);
        drive(1'b1, 1'b0, 3, 0);
        idle(2);

        // Back-to-back reads of preloaded words
        drive(1'b1, 1'b1, 1, 8'h11);
        drive(1'b1, 1'b1, 2, 8'h22);
        drive(1'b1, 1'b1, 3, 8'h33);
        drive(1'b1, 1'b0, 1, 0);
        drive(1'b1, 1'b0, 2, 0);
        drive(1'b1, 1'b0, 3, 0);
        idle(3);

        // Boundary: address 12 is the first out-of-range word for u_a
        drive(1'b1, 1'b1, 11, 8'h77);
        drive(1'b1, 1'b1, 12, 8'h5A);
        drive(1'b1, 1'b1, 12, 8'hFF);
        drive(1'b1, 1'b0, 12, 0);
        drive(1'b1, 1'b0, 11, 0);
        drive(1'b1, 1'b0, 4095, 0);
        idle(3);

        rand_ops(300, 0);
        idle(3);

        // Contents survive reset without a sweep; sweep restarts mid-way
        drive(1'b1, 1'b1, 5, 8'h3C);
        rst = 1'b1;
        idle(1);
        release_rst();
        idle(7);
        rst = 1'b1;
        idle(1);
        release_rst();
        for (int k = 0; k < 18; k++) drive(1'b1, 1'b0, 5, 0);
        idle(2);

        // Reset one cycle after a read accept drops the pending completion
        drive(1'b1, 1'b0, 2, 0);
        rst = 1'b1;
        idle(1);
        release_rst();
        idle(18);

        rand_ops(300, 40);
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
